// File: rtl/btn_pio_pkg.sv
// Shared definitions for the button PIO: register map addresses and the
// per-channel edge-mode encoding used by the capture logic.
package btn_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_EDGE_MODE = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_RAW       = 3'd4;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // True when the transition prev->cur is one the channel's mode cares about.
  function automatic logic edge_hit(edge_mode_e mode, logic cur, logic prev);
    case (mode)
      EDGE_RISE: edge_hit = cur & ~prev;
      EDGE_FALL: edge_hit = ~cur & prev;
      EDGE_BOTH: edge_hit = cur ^ prev;
      default:   edge_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_pio_debounce_if.sv
// Avalon-MM slave bus of the button PIO, plus its interrupt line.
interface btn_pio_debounce_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: metastability synchronizer followed by a
// stable-count debouncer that commits a new level after DEBOUNCE_CYCLES.
module btn_debounce_ch
  import btn_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic debounced
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any agreement between synchronized and debounced level restarts the count,
  // so only an unbroken run of mismatches can flip the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      count     <= '0;
      debounced <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (sync == debounced) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        debounced <= sync;
        count     <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_pio_debounce.sv
// Debounced button PIO with per-channel edge capture, interrupt masking
// and a fixed-latency-1 Avalon-MM register interface.
module btn_pio_debounce
  import btn_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  btn_pio_debounce_if.slave bus
);

  logic [WIDTH-1:0]   sync_bits;
  logic [WIDTH-1:0]   deb_bits;
  logic [WIDTH-1:0]   deb_prev;
  logic [WIDTH-1:0]   edge_hits;
  logic [WIDTH-1:0]   edge_cap;
  logic [WIDTH-1:0]   irq_mask;
  logic [WIDTH-1:0]   clr_bits;
  logic [2*WIDTH-1:0] edge_mode;
  logic [31:0]        rd_next;
  logic               wr_en;
  logic               unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (in_port[i]),
      .sync     (sync_bits[i]),
      .debounced(deb_bits[i])
    );
    assign edge_hits[i] = edge_hit(edge_mode_e'(edge_mode[2*i +: 2]),
                                   deb_bits[i], deb_prev[i]);
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign clr_bits     = (wr_en && bus.address == ADDR_EDGE_CAP) ?
                        bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = &{1'b0, bus.writedata};
  assign bus.irq      = |(edge_cap & irq_mask);

  // A fresh edge is OR-ed in after the clear so a coincident W1C never loses it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev  <= '0;
      edge_cap  <= '0;
      edge_mode <= '0;
      irq_mask  <= '0;
    end else begin
      deb_prev <= deb_bits;
      edge_cap <= (edge_cap & ~clr_bits) | edge_hits;
      if (wr_en && bus.address == ADDR_EDGE_MODE)
        edge_mode <= bus.writedata[2*WIDTH-1:0];
      if (wr_en && bus.address == ADDR_IRQ_MASK)
        irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:      rd_next[WIDTH-1:0]   = deb_bits;
      ADDR_EDGE_MODE: rd_next[2*WIDTH-1:0] = edge_mode;
      ADDR_IRQ_MASK:  rd_next[WIDTH-1:0]   = irq_mask;
      ADDR_EDGE_CAP:  rd_next[WIDTH-1:0]   = edge_cap;
      ADDR_RAW:       rd_next[WIDTH-1:0]   = sync_bits;
      default:        rd_next              = '0;
    endcase
  end

  // Reads are not qualified by chipselect; the bus samples one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_next;
  end

endmodule

// File: tb/tb_btn_pio_debounce.sv
// Self-checking bench for btn_pio_debounce: directed scenarios plus a random
// soak, all compared against a window-based behavioural model.
module tb_btn_pio_debounce;
  import btn_pio_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int SYNC  = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_port = '0;
  int               checks = 0;
  int               errors = 0;

  btn_pio_debounce_if bus();

  btn_pio_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a level commits once the synchronized input (in_port as
  // seen SYNC edges earlier) has disagreed with it for DEB consecutive edges.
  logic [WIDTH-1:0]   hist[$];
  logic [WIDTH-1:0]   m_deb  = '0;
  logic [WIDTH-1:0]   m_cap  = '0;
  logic [WIDTH-1:0]   m_mask = '0;
  logic [WIDTH-1:0]   m_rise = '0;
  logic [WIDTH-1:0]   m_fall = '0;
  logic [2*WIDTH-1:0] m_mode = '0;
  logic [31:0]        m_rd   = '0;
  logic               m_irq;

  assign m_irq = |(m_cap & m_mask);

  function automatic logic [WIDTH-1:0] seen_at(int back);
    int idx;
    idx = hist.size() - 1 - SYNC - back;
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [WIDTH-1:0] flips, clr, hit, s;
    logic [31:0]      nxt_rd;
    logic             wr;
    if (reset) begin
      hist.delete();
      m_deb = '0; m_cap = '0; m_mask = '0; m_mode = '0;
      m_rise = '0; m_fall = '0; m_rd = '0;
    end else begin
      hist.push_back(in_port);
      if (hist.size() > 16) void'(hist.pop_front());
      wr = bus.chipselect && !bus.write_n;
      case (bus.address)
        3'd0:    nxt_rd = 32'(m_deb);
        3'd1:    nxt_rd = 32'(m_mode);
        3'd2:    nxt_rd = 32'(m_mask);
        3'd3:    nxt_rd = 32'(m_cap);
        3'd4:    nxt_rd = 32'(seen_at(0));
        default: nxt_rd = 32'h0;
      endcase
      hit = '0;
      for (int i = 0; i < WIDTH; i++)
        hit[i] = (m_rise[i] & m_mode[2*i]) | (m_fall[i] & m_mode[2*i+1]);
      clr = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
      m_cap = (m_cap & ~clr) | hit;
      if (wr && bus.address == 3'd1) m_mode = bus.writedata[2*WIDTH-1:0];
      if (wr && bus.address == 3'd2) m_mask = bus.writedata[WIDTH-1:0];
      flips = '1;
      for (int j = 0; j < DEB; j++) begin
        s = seen_at(j);
        flips = flips & (s ^ m_deb);
      end
      m_rise = flips & ~m_deb;
      m_fall = flips & m_deb;
      m_deb  = m_deb ^ flips;
      m_rd   = nxt_rd;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus.address = addr;
    @(posedge clk);
    @(negedge clk);
    data = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    in_port = '0;
    tick(3);
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_irq: got %b expected 0", bus.irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      bus_read(3'(a), rd);
      checks++;
      if (rd !== 32'h0 || rd !== m_rd) begin
        errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, rd, 32'h0);
      end
    end
  endtask

  task automatic test_step();
    logic [31:0] exp;
    bus.address = ADDR_DATA;
    tick(2);
    in_port[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      exp = (n >= 7) ? 32'h1 : 32'h0;
      checks++;
      if (bus.readdata !== exp || bus.readdata !== m_rd) begin
        errors++; $display("[TB] FAIL step_latency cycle %0d: got %h expected %h", n, bus.readdata, exp);
      end
    end
    in_port[0] = 1'b0;
    tick(10);
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    bus_write(ADDR_EDGE_MODE, 32'hC);
    in_port[1] = 1'b1;
    tick(3);
    in_port[1] = 1'b0;
    tick(10);
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'h0 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL glitch3_data: got %h expected %h", rd, 32'h0);
    end
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h0 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL glitch3_cap: got %h expected %h", rd, 32'h0);
    end
    bus.address = ADDR_DATA;
    in_port[1] = 1'b1;
    tick(6);
    in_port[1] = 1'b0;
    tick(1);
    checks++;
    if (bus.readdata !== 32'h2 || bus.readdata !== m_rd) begin
      errors++; $display("[TB] FAIL glitch6_data: got %h expected %h", bus.readdata, 32'h2);
    end
    tick(10);
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h2 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL glitch6_cap: got %h expected %h", rd, 32'h2);
    end
    bus_write(ADDR_EDGE_CAP, 32'hF);
    bus_write(ADDR_EDGE_MODE, 32'h0);
  endtask

  task automatic test_falling();
    logic [31:0] rd;
    bus_write(ADDR_EDGE_MODE, 32'h8);
    bus_write(ADDR_IRQ_MASK, 32'h2);
    in_port[1] = 1'b1;
    tick(10);
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h0 || bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL fall_after_press: got cap %h irq %b expected cap 0 irq 0", rd, bus.irq);
    end
    in_port[1] = 1'b0;
    tick(10);
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h2 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL fall_cap: got %h expected %h", rd, 32'h2);
    end
    checks++;
    if (bus.irq !== 1'b1 || bus.irq !== m_irq) begin
      errors++; $display("[TB] FAIL fall_irq: got %b expected 1", bus.irq);
    end
    bus_write(ADDR_EDGE_CAP, 32'h2);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL fall_w1c_irq: got %b expected 0", bus.irq);
    end
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h0 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL fall_w1c_cap: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_both_mask();
    logic [31:0] rd;
    bus_write(ADDR_EDGE_MODE, 32'hFF);
    bus_write(ADDR_IRQ_MASK, 32'h0);
    in_port[2] = 1'b1;
    tick(10);
    in_port[2] = 1'b0;
    tick(10);
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h4 || rd !== m_rd || bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL both_cap: got cap %h irq %b expected cap 4 irq 0", rd, bus.irq);
    end
    bus_write(ADDR_IRQ_MASK, 32'h4);
    checks++;
    if (bus.irq !== 1'b1 || bus.irq !== m_irq) begin
      errors++; $display("[TB] FAIL both_mask_irq: got %b expected 1", bus.irq);
    end
    bus_write(ADDR_EDGE_CAP, 32'hF);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL both_clear_irq: got %b expected 0", bus.irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    in_port[3] = 1'b1;
    tick(10);
    in_port[3] = 1'b0;
    tick(6);
    bus_write(ADDR_EDGE_CAP, 32'h8);
    bus_read(ADDR_EDGE_CAP, rd);
    checks++;
    if (rd !== 32'h8 || rd !== m_rd) begin
      errors++; $display("[TB] FAIL b2b_set_wins: got %h expected %h", rd, 32'h8);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd;
    logic [31:0] exp;
    bus_write(ADDR_IRQ_MASK, 32'hF);
    bus.address = ADDR_DATA;
    tick(10);
    in_port[0] = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_out: got rd %h irq %b expected rd 0 irq 0", bus.readdata, bus.irq);
    end
    tick(2);
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      exp = (n >= 7) ? 32'h1 : 32'h0;
      checks++;
      if (bus.readdata !== exp || bus.readdata !== m_rd) begin
        errors++; $display("[TB] FAIL midreset_rise cycle %0d: got %h expected %h", n, bus.readdata, exp);
      end
    end
    for (int a = 1; a < 4; a++) begin
      bus_read(3'(a), rd);
      checks++;
      if (rd !== 32'h0 || rd !== m_rd) begin
        errors++; $display("[TB] FAIL midreset_reg%0d: got %h expected %h", a, rd, 32'h0);
      end
    end
    in_port = '0;
    tick(10);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = $urandom();
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = ($urandom_range(0, 3) != 0);
      tick(1);
      checks++;
      if (bus.readdata !== m_rd) begin
        errors++; $display("[TB] FAIL random_rd cycle %0d: got %h expected %h", n, bus.readdata, m_rd);
      end
      checks++;
      if (bus.irq !== m_irq) begin
        errors++; $display("[TB] FAIL random_irq cycle %0d: got %b expected %b", n, bus.irq, m_irq);
      end
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_step();
    test_glitch();
    test_falling();
    test_both_mask();
    test_back_to_back();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/btn_pio_debounce.md
BTN_PIO_DEBOUNCE -- requirements
Module: btn_pio_debounce

Interface
REQ-001 Parameter WIDTH, default 4, number of input channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required before a debounced bit changes (>=1).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (>=2).
REQ-004 clk  in  1  sole clock; all state rising-edge clocked.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  WIDTH  raw asynchronous button inputs.
REQ-011 readdata  out  32  registered read data, unused upper bits zero.
REQ-012 irq  out  1  level interrupt, OR of (edge_capture AND irq_mask).

Function
REQ-013 Register map: 0 debounced data (RO), 1 edge_mode (RW, 2 bits per channel at bits [2i+1:2i]), 2 irq_mask (RW, WIDTH bits), 3 edge_capture (W1C, WIDTH bits), 4 raw synchronized input (RO); addresses 5-7 read zero and ignore writes.
REQ-014 readdata shall update every cycle from the addressed register (one-cycle read latency, no chipselect qualification), matching Avalon fixed-latency-1 reads.
REQ-015 Each in_port bit shall pass through SYNC_STAGES flops before any other use.
REQ-016 Per channel, a counter of width clog2(DEBOUNCE_CYCLES+1) shall reset to 0 whenever the synchronized bit equals the debounced bit, and increment otherwise.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the debounced bit shall take the synchronized value on that clock edge and the counter shall return to 0; the counter never wraps.
REQ-018 Total latency from in_port change to debounced change shall be exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles for a clean step.
REQ-019 edge_mode per channel: 00 disabled, 01 rising, 10 falling, 11 both; detection compares debounced bit to its one-cycle-delayed copy.
REQ-020 A detected enabled edge shall set the corresponding edge_capture bit on the next clock edge.
REQ-021 Write to address 3 clears exactly the bits where writedata is 1; other bits unaffected.
REQ-022 Simultaneous W1C and new edge on the same bit in the same cycle: set wins (event not lost).
REQ-023 Changing edge_mode or irq_mask shall not alter edge_capture; irq follows mask changes combinationally from registered state within the same cycle.
REQ-024 Writes to registers 1 and 2 take effect on the clock edge of the write; writedata bits beyond the register width are ignored.

Reset
REQ-025 On reset: readdata 0, irq 0, irq_mask 0, edge_mode 0, edge_capture 0, synchronizer flops 0, debounced bits 0, delayed copies 0, counters 0.
REQ-026 Reset asserted mid-debounce shall abort the count; after release a held-high input produces its debounced rise after the full REQ-018 latency, and, if rising enabled, an edge.

Structure
REQ-027 Shared package btn_pio_pkg holds register address constants (ADDR_DATA..ADDR_RAW) and edge_mode encodings (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-028 One sub-module btn_debounce_ch (synchronizer + counter + debounced bit for one channel), instantiated WIDTH times by generate; register file, edge logic and read mux stay in the top.

Verification (bench: WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 Step in_port[0] 0->1 held -> data reg bit0 reads 1 exactly 6 cycles later; read of address 0 returns 0x1 one cycle after address is presented.
REQ-030 Glitch in_port[1] high for 3 cycles then low -> debounced data, edge_capture remain 0x0; glitch of 6 cycles -> bit1 sets.
REQ-031 edge_mode=0x00000008 (ch1 falling), mask=0x2; press then release ch1 -> edge_capture=0x2 only after release, irq=1; write 0x2 to addr 3 -> edge_capture=0x0, irq=0 next cycle.
REQ-032 edge_mode=0xFF (all both), mask=0x0; toggle ch2 -> edge_capture=0x4, irq=0; write mask=0x4 -> irq=1 without further edges.
REQ-033 W1C of bit3 in same cycle as new ch3 edge -> edge_capture bit3 stays 1.
REQ-034 Assert reset mid-count on ch0 with input held high -> all registers 0; after release debounced bit0 rises after 6 cycles.
